// File: rtl/i2c_eeprom_seq.sv
// i2c_eeprom_seq: byte-write / random-read EEPROM transaction sequencer driving an I2C byte controller.
module i2c_eeprom_seq #(
   parameter int TIMEOUT_CYC = 65535,
   parameter int TO_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_word,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_err,
   output logic       cmd_start,
   output logic       cmd_stop,
   output logic       cmd_read,
   output logic       cmd_write,
   output logic       cmd_ack_in,
   output logic [7:0] cmd_din,
   input  logic       cmd_ack,
   input  logic       rx_ack,
   input  logic [7:0] rx_dout,
   input  logic       i2c_al
);
   typedef enum logic [2:0] {IDLE, DEV_W, WORD, WDATA, DEV_R, RDATA, ERR_STOP, DONE} state_t;
   state_t state, nxt;
   logic rw, gap, active, ack, tmo;
   logic [6:0] dev;
   logic [7:0] word, wdata;
   logic [1:0] err;
   logic [TO_W-1:0] cnt;
   // gap marks the cycle after an accepted cmd_ack, when every command bit must be low
   assign active = state != IDLE && state != DONE;
   assign ack    = active && cmd_ack && !gap;
   assign tmo    = active && cnt == TO_W'(TIMEOUT_CYC);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = req_valid ? DEV_W : IDLE;
         DONE:    nxt = IDLE;
         default:
            if (i2c_al) nxt = DONE;
            else if (ack)
               case (state)
                  DEV_W:   nxt = rx_ack ? ERR_STOP : WORD;
                  WORD:    nxt = rx_ack ? ERR_STOP : (rw ? DEV_R : WDATA);
                  DEV_R:   nxt = rx_ack ? ERR_STOP : RDATA;
                  default: nxt = DONE;
               endcase
            else if (tmo) nxt = DONE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rw        <= 1'b0;
         dev       <= 7'h00;
         word      <= 8'h00;
         wdata     <= 8'h00;
         err       <= 2'd0;
         cnt       <= '0;
         gap       <= 1'b0;
         rsp_rdata <= 8'h00;
      end else begin
         gap <= ack;
         cnt <= (nxt != state) ? '0 : active ? cnt + 1'b1 : '0;
         if (state == IDLE && req_valid) begin
            rw    <= req_rw;
            dev   <= req_dev;
            word  <= req_word;
            wdata <= req_wdata;
            err   <= 2'd0;
         end else if (active) begin
            if (i2c_al) err <= 2'd2;
            else if (ack && rx_ack && state inside {DEV_W, WORD, WDATA, DEV_R}) err <= 2'd1;
            else if (!ack && tmo) err <= 2'd3;
         end
         if (state == RDATA && ack && !i2c_al) rsp_rdata <= rx_dout;
      end
   always_comb begin
      cmd_start  = !gap && state inside {DEV_W, DEV_R};
      cmd_write  = !gap && state inside {DEV_W, WORD, WDATA, DEV_R};
      cmd_stop   = !gap && state inside {WDATA, RDATA, ERR_STOP};
      cmd_read   = !gap && state == RDATA;
      cmd_ack_in = cmd_read;
      cmd_din    = gap ? 8'h00 : state == DEV_W ? {dev, 1'b0} : state == WORD ? word :
                   state == WDATA ? wdata : state == DEV_R ? {dev, 1'b1} : 8'h00;
      req_ready  = state == IDLE;
      rsp_valid  = state == DONE;
      rsp_err    = rsp_valid ? err : 2'd0;
   end
endmodule
